// File: rtl/roulette_wheel_spin_if.sv
// Handshake bundle between the roulette wheel and its consumer.
// The consumer side (master) requests spins and acknowledges results.
interface roulette_wheel_spin_if;
  logic       spin;
  logic       ack;
  logic [4:0] randnum;
  logic       result_valid;
  logic       spinning;
  logic [4:0] pocket;
  logic [7:0] spin_count;

  modport master (
    output spin,
    output ack,
    input  randnum,
    input  result_valid,
    input  spinning,
    input  pocket,
    input  spin_count
  );

  modport slave (
    input  spin,
    input  ack,
    output randnum,
    output result_valid,
    output spinning,
    output pocket,
    output spin_count
  );
endinterface

// File: rtl/roulette_wheel_spin.sv
// Animated roulette wheel: a spin request walks the pocket forward with a slowing step rate,
// then holds the landing pocket until the consumer acknowledges it.
module roulette_wheel_spin #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter logic [15:0] STEP_INIT  = 16'd4,
  parameter logic [15:0] STEP_GROW  = 16'd2,
  parameter logic [7:0]  NUM_STEPS  = 8'd24,
  parameter int          RAND_EXTRA = 1
) (
  input logic                  Clock,
  input logic                  reset,
  roulette_wheel_spin_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsrNext;
  logic [15:0] period;
  logic [15:0] tick;
  logic [8:0]  step;
  logic [8:0]  target;
  logic        spin_q;
  logic [4:0]  pocketReg;
  logic [4:0]  randnumReg;
  logic        resultValidReg;
  logic [7:0]  spinCountReg;

  logic        spinEdge;
  logic        lastTick;
  logic [8:0]  stepNext;
  logic [8:0]  extraSteps;
  logic [4:0]  pocketNext;
  logic [16:0] periodSum;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  assign lfsrNext   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  assign spinEdge   = bus.spin & ~spin_q;
  assign lastTick   = (tick == (period - 16'd1));
  assign stepNext   = step + 9'd1;
  assign pocketNext = pocketReg + 5'd1;
  assign periodSum  = {1'b0, period} + {1'b0, STEP_GROW};
  assign extraSteps = (RAND_EXTRA != 0) ? {6'd0, lfsr[2:0]} : 9'd0;

  // The >= compare lets a zero target still end after exactly one advance
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lfsr           <= SEED;
      spin_q         <= 1'b0;
      pocketReg      <= 5'd0;
      randnumReg     <= 5'd0;
      resultValidReg <= 1'b0;
      spinCountReg   <= 8'd0;
      tick           <= 16'd0;
      step           <= 9'd0;
      target         <= 9'd0;
      period         <= STEP_INIT;
    end else begin
      lfsr   <= lfsrNext;
      spin_q <= bus.spin;
      case (state)
        IDLE: begin
          if (spinEdge) begin
            state     <= SPIN;
            pocketReg <= lfsr[4:0];
            period    <= STEP_INIT;
            tick      <= 16'd0;
            step      <= 9'd0;
            target    <= {1'b0, NUM_STEPS} + extraSteps;
          end
        end
        SPIN: begin
          if (lastTick) begin
            pocketReg <= pocketNext;
            tick      <= 16'd0;
            step      <= stepNext;
            period    <= periodSum[16] ? 16'hFFFF : periodSum[15:0];
            if (stepNext >= target) begin
              randnumReg     <= pocketNext;
              resultValidReg <= 1'b1;
              state          <= HOLD;
            end
          end else begin
            tick <= tick + 16'd1;
          end
        end
        HOLD: begin
          if (bus.ack) begin
            resultValidReg <= 1'b0;
            state          <= IDLE;
            if (spinCountReg != 8'hFF) begin
              spinCountReg <= spinCountReg + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.randnum      = randnumReg;
  assign bus.result_valid = resultValidReg;
  assign bus.spinning     = (state == SPIN);
  assign bus.pocket       = pocketReg;
  assign bus.spin_count   = spinCountReg;

endmodule

// File: tb/tb_roulette_wheel_spin.sv
// Scoreboard bench for roulette_wheel_spin: three wheels with different parameters share
// one clock and reset; landing pockets are predicted when spins are requested.
module tb_roulette_wheel_spin;

  logic Clock;
  logic reset;

  roulette_wheel_spin_if busA ();
  roulette_wheel_spin_if busB ();
  roulette_wheel_spin_if busC ();

  roulette_wheel_spin #(
    .SEED(16'h0001), .STEP_INIT(16'd2), .STEP_GROW(16'd1), .NUM_STEPS(8'd3), .RAND_EXTRA(0)
  ) dutA (.Clock(Clock), .reset(reset), .bus(busA));

  roulette_wheel_spin #(
    .SEED(16'h001F), .STEP_INIT(16'd4), .STEP_GROW(16'd2), .NUM_STEPS(8'd1), .RAND_EXTRA(0)
  ) dutB (.Clock(Clock), .reset(reset), .bus(busB));

  roulette_wheel_spin dutC (.Clock(Clock), .reset(reset), .bus(busC));

  int          checkCount = 0;
  int          errorCount = 0;
  logic [4:0]  qA[$];
  logic [4:0]  qB[$];
  logic [4:0]  qC[$];
  logic [15:0] mdlLfsrA;
  logic        prevRvA = 1'b0;
  logic        prevRvB = 1'b0;
  logic        prevRvC = 1'b0;
  logic [4:0]  pocketExp [10] = '{5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd4};
  logic [4:0]  start;
  int          n;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference LFSR for wheel A so later start pockets can be predicted
  always @(posedge Clock or posedge reset) begin
    if (reset) mdlLfsrA <= 16'h0001;
    else       mdlLfsrA <= {1'b0, mdlLfsrA[15:1]} ^ (mdlLfsrA[0] ? 16'hB400 : 16'h0000);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    busA.spin = s;
    busA.ack  = a;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic waitForValid(input int budget);
    int k = 0;
    while (busA.result_valid !== 1'b1 && k < budget) begin
      @(posedge Clock);
      @(negedge Clock);
      k++;
    end
    checkOutput("A_valid_timeout", busA.result_valid, 1);
  endtask

  // Each rising result_valid consumes one predicted landing pocket
  always @(negedge Clock) begin
    if (busA.result_valid === 1'b1 && prevRvA !== 1'b1) begin
      checkOutput("A_result_pending", 32'(qA.size() != 0), 1);
      if (qA.size() != 0) checkOutput("A_randnum_sb", busA.randnum, qA.pop_front());
    end
    if (busB.result_valid === 1'b1 && prevRvB !== 1'b1) begin
      checkOutput("B_result_pending", 32'(qB.size() != 0), 1);
      if (qB.size() != 0) checkOutput("B_randnum_sb", busB.randnum, qB.pop_front());
    end
    if (busC.result_valid === 1'b1 && prevRvC !== 1'b1) begin
      checkOutput("C_result_pending", 32'(qC.size() != 0), 1);
      if (qC.size() != 0) checkOutput("C_randnum_sb", busC.randnum, qC.pop_front());
    end
    prevRvA <= busA.result_valid;
    prevRvB <= busB.result_valid;
    prevRvC <= busC.result_valid;
  end

  initial begin
    reset     = 1'b1;
    busA.spin = 1'b0; busA.ack = 1'b0;
    busB.spin = 1'b0; busB.ack = 1'b0;
    busC.spin = 1'b0; busC.ack = 1'b0;
    repeat (3) @(negedge Clock);
    checkOutput("rst_randnum", busA.randnum, 0);
    checkOutput("rst_valid", busA.result_valid, 0);
    checkOutput("rst_pocket", busA.pocket, 0);
    checkOutput("rst_count", busA.spin_count, 0);
    checkOutput("rst_spinning", busA.spinning, 0);

    // Release reset with spin already high so the first edge (E0) starts every wheel
    reset     = 1'b0;
    busA.spin = 1'b1;
    busB.spin = 1'b1;
    busC.spin = 1'b1;
    qA.push_back(5'd4);
    qB.push_back(5'd0);
    qC.push_back(5'd26);
    for (int k = 0; k < 10; k++) begin
      @(posedge Clock);
      @(negedge Clock);
      checkOutput($sformatf("A_pocket_E%0d", k), busA.pocket, pocketExp[k]);
      checkOutput($sformatf("A_spinning_E%0d", k), busA.spinning, 32'(k < 9));
      if (k == 0) begin
        checkOutput("B_start_pocket", busB.pocket, 31);
        checkOutput("C_start_pocket", busC.pocket, 1);
        busB.spin = 1'b0;
        busC.spin = 1'b0;
      end
    end
    checkOutput("A_valid_E9", busA.result_valid, 1);
    checkOutput("A_randnum_E9", busA.randnum, 4);

    for (int k = 0; k < 50; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("hold_valid", busA.result_valid, 1);
      checkOutput("hold_randnum", busA.randnum, 4);
      checkOutput("hold_pocket", busA.pocket, 4);
    end

    busB.ack = 1'b1;
    applyStimulus(1'b1, 1'b1);
    busB.ack = 1'b0;
    checkOutput("ack_valid", busA.result_valid, 0);
    checkOutput("ack_count", busA.spin_count, 1);
    checkOutput("ack_randnum_kept", busA.randnum, 4);
    checkOutput("B_ack_count", busB.spin_count, 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("idle_spinning", busA.spinning, 0);
    checkOutput("idle_valid", busA.result_valid, 0);

    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("held_no_respin", busA.spinning, 0);
    end

    applyStimulus(1'b0, 1'b0);
    start = mdlLfsrA[4:0];
    qA.push_back(start + 5'd3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("respin_spinning", busA.spinning, 1);
    checkOutput("respin_pocket", busA.pocket, start);
    applyStimulus(1'b0, 1'b0);
    waitForValid(200);

    applyStimulus(1'b1, 1'b1);
    checkOutput("ackspin_valid", busA.result_valid, 0);
    checkOutput("ackspin_spinning", busA.spinning, 0);
    checkOutput("ackspin_count", busA.spin_count, 2);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("ackspin_no_respin", busA.spinning, 0);
    end
    applyStimulus(1'b0, 1'b0);

    n = 0;
    while (qC.size() != 0 && n < 2000) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkOutput("C_drained", qC.size(), 0);
    checkOutput("B_drained", qB.size(), 0);

    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("midspin_spinning", busA.spinning, 1);
    reset     = 1'b1;
    busA.spin = 1'b0;
    #1;
    checkOutput("abort_randnum", busA.randnum, 0);
    checkOutput("abort_valid", busA.result_valid, 0);
    checkOutput("abort_pocket", busA.pocket, 0);
    checkOutput("abort_count", busA.spin_count, 0);
    checkOutput("abort_spinning", busA.spinning, 0);
    @(negedge Clock);
    @(negedge Clock);
    reset = 1'b0;
    qA.push_back(5'd4);
    applyStimulus(1'b1, 1'b0);
    checkOutput("post_rst_pocket", busA.pocket, 1);
    checkOutput("post_rst_spinning", busA.spinning, 1);
    applyStimulus(1'b0, 1'b0);
    waitForValid(200);
    applyStimulus(1'b0, 1'b1);
    checkOutput("post_rst_count", busA.spin_count, 1);
    checkOutput("post_rst_valid", busA.result_valid, 0);
    busA.ack = 1'b0;
    checkOutput("A_drained", qA.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
